// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage plus the integer register file.
//
// Selects the writeback value (load data or ALU result). When the WB-stage
// instruction commits, it writes that value into a 32-entry register file.
// Register x0 is hardwired to zero. The block serves two combinational read
// ports to ID with same-cycle write-through bypass. It also keeps a 64-bit
// count of retired instructions.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   stall                 WB instruction is being held (shared with MEMWB)
//   wb_valid              WB stage holds a real instruction
//   MemtoReg              1 = writeback load data, 0 = writeback ALU result
//   RegWrite              instruction writes rd
//   rd                    destination register index
//   rd_MemData            load data from MEM
//   ALU_result            ALU result
//   rs1_addr, rs2_addr    ID-stage read indices
//   rs1_data, rs2_data    combinational read data (with bypass)
//   wb_we_o, wb_rd_o      commit-write strobe and its destination
//   wb_data_o             selected writeback value (for EX forwarding)
//   instret               registered retired-instruction count
module wb_regfile #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 wb_valid,
  input  logic                 MemtoReg,
  input  logic                 RegWrite,
  input  logic [4:0]           rd,
  input  logic [DATAWIDTH-1:0] rd_MemData,
  input  logic [DATAWIDTH-1:0] ALU_result,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic [DATAWIDTH-1:0] rs1_data,
  output logic [DATAWIDTH-1:0] rs2_data,
  output logic                 wb_we_o,
  output logic [4:0]           wb_rd_o,
  output logic [DATAWIDTH-1:0] wb_data_o,
  output logic [63:0]          instret
);

  // x0 is never stored, so the array only covers x1..x31.
  logic [DATAWIDTH-1:0] r_regs [1:31];
  logic [63:0]          r_instret;

  logic [DATAWIDTH-1:0] w_wbData;
  logic                 w_commit;
  logic                 w_we;

  assign w_wbData = MemtoReg ? rd_MemData : ALU_result;

  // A held (stalled) instruction is presented repeatedly. It commits only in
  // its stall-low cycle. Reset drops whatever is in flight.
  assign w_commit = wb_valid & ~stall & ~rst;
  assign w_we     = w_commit & RegWrite & (rd != 5'd0);

  assign wb_we_o   = w_we;
  assign wb_rd_o   = rd;
  assign wb_data_o = w_wbData;
  assign instret   = r_instret;

  // Register array and retire counter. The counter advances on every commit,
  // including commits that do not write a register. It wraps naturally at 2^64.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
      end
      r_instret <= '0;
    end else begin
      if (w_we) begin
        r_regs[rd] <= w_wbData;
      end
      if (w_commit) begin
        r_instret <= r_instret + 64'd1;
      end
    end
  end

  // Read port 1. The read is write-first: a matching commit in this cycle is
  // returned before the array has been updated.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      if (w_we && (rd == rs1_addr)) begin
        rs1_data = w_wbData;
      end else begin
        rs1_data = r_regs[rs1_addr];
      end
    end
  end

  // Read port 2. This port works the same way as port 1.
  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      if (w_we && (rd == rs2_addr)) begin
        rs2_data = w_wbData;
      end else begin
        rs2_data = r_regs[rs2_addr];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile.
//
// The stimulus process drives one cycle of inputs just after each posedge.
// For that cycle it queues the hand-computed expected outputs. A separate
// monitor samples on the negedge and checks the queued entries for the
// current cycle.
module tb_wb_regfile;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          wb_valid;
  logic          MemtoReg;
  logic          RegWrite;
  logic [4:0]    rd;
  logic [DW-1:0] rd_MemData;
  logic [DW-1:0] ALU_result;
  logic [4:0]    rs1_addr;
  logic [4:0]    rs2_addr;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          wb_we_o;
  logic [4:0]    wb_rd_o;
  logic [DW-1:0] wb_data_o;
  logic [63:0]   instret;

  wb_regfile #(.DATAWIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .wb_valid   (wb_valid),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .rd         (rd),
    .rd_MemData (rd_MemData),
    .ALU_result (ALU_result),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .wb_we_o    (wb_we_o),
    .wb_rd_o    (wb_rd_o),
    .wb_data_o  (wb_data_o),
    .instret    (instret)
  );

  // Output selectors for scoreboard entries.
  localparam int S_RS1  = 0;
  localparam int S_RS2  = 1;
  localparam int S_WE   = 2;
  localparam int S_RD   = 3;
  localparam int S_DATA = 4;
  localparam int S_CNT  = 5;

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] exp;
    string       name;
  } expT;

  expT expQ[$];
  int  cycCount  = 0;
  int  checks    = 0;
  int  passes    = 0;
  int  failures  = 0;

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index. Stimulus reads it after the posedge, and the monitor reads
  // it at the following negedge.
  always @(posedge clk) cycCount <= cycCount + 1;

  // Queue one expected output value for the cycle currently being driven.
  task automatic expectOut(input int sel, input logic [63:0] exp, input string name);
    expT e;
    e.cyc  = cycCount;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    expQ.push_back(e);
  endtask

  // Drive one cycle of inputs shortly after the posedge.
  task automatic applyStimulus(
    input logic          rstV,
    input logic          stallV,
    input logic          validV,
    input logic          memV,
    input logic          rwV,
    input logic [4:0]    rdV,
    input logic [DW-1:0] memData,
    input logic [DW-1:0] alu,
    input logic [4:0]    a1,
    input logic [4:0]    a2
  );
    @(posedge clk);
    #1;
    rst        = rstV;
    stall      = stallV;
    wb_valid   = validV;
    MemtoReg   = memV;
    RegWrite   = rwV;
    rd         = rdV;
    rd_MemData = memData;
    ALU_result = alu;
    rs1_addr   = a1;
    rs2_addr   = a2;
  endtask

  // Compare one scoreboard entry against the sampled DUT outputs.
  task automatic checkOutput(input expT e);
    logic [63:0] act;
    case (e.sel)
      S_RS1:   act = {32'd0, rs1_data};
      S_RS2:   act = {32'd0, rs2_data};
      S_WE:    act = {63'd0, wb_we_o};
      S_RD:    act = {59'd0, wb_rd_o};
      S_DATA:  act = {32'd0, wb_data_o};
      default: act = instret;
    endcase
    checks++;
    if (act === e.exp) begin
      passes++;
    end else begin
      failures++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", e.name, e.cyc, act, e.exp);
    end
  endtask

  // Monitor: on each negedge, pop and check every entry queued for this cycle.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cycCount) begin
      if (expQ[0].cyc < cycCount) begin
        checks++;
        failures++;
        $display("[TB] FAIL stale_%s: entry for cycle %0d unchecked at cycle %0d", expQ[0].name, expQ[0].cyc, cycCount);
        void'(expQ.pop_front());
      end else begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; wb_valid = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
    rd = '0; rd_MemData = '0; ALU_result = '0; rs1_addr = '0; rs2_addr = '0;

    // Reset is held for two cycles while commit inputs are active.
    applyStimulus(1, 0, 1, 0, 1, 5'd5, 32'h0, 32'hDEAD, 5'd5, 5'd1);
    expectOut(S_WE, 0, "rst_we_c1");
    applyStimulus(1, 0, 1, 0, 1, 5'd5, 32'h0, 32'hDEAD, 5'd5, 5'd1);
    expectOut(S_WE, 0, "rst_we_c2");
    expectOut(S_RS1, 0, "rst_x5");
    expectOut(S_RS2, 0, "rst_x1");
    expectOut(S_CNT, 0, "rst_instret");
    applyStimulus(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd1);
    expectOut(S_RS1, 0, "rst_dropped_x5");
    expectOut(S_CNT, 0, "rst_instret_after");

    // Writeback mux: commit the ALU result, then commit load data.
    applyStimulus(0, 0, 1, 0, 1, 5'd3, 32'h77, 32'h11, 5'd3, 5'd0);
    expectOut(S_WE, 1, "mux_we_alu");
    expectOut(S_RD, 3, "mux_rd_alu");
    expectOut(S_DATA, 32'h11, "mux_data_alu");
    expectOut(S_RS1, 32'h11, "mux_bypass_x3");
    applyStimulus(0, 0, 1, 1, 1, 5'd4, 32'h22, 32'h99, 5'd3, 5'd4);
    expectOut(S_DATA, 32'h22, "mux_data_mem");
    expectOut(S_RS1, 32'h11, "mux_array_x3");
    expectOut(S_RS2, 32'h22, "mux_bypass_x4");
    expectOut(S_CNT, 1, "mux_instret1");
    applyStimulus(0, 0, 0, 1, 1, 5'd4, 32'h22, 32'h99, 5'd3, 5'd4);
    expectOut(S_WE, 0, "bubble_we");
    expectOut(S_RS1, 32'h11, "mux_x3");
    expectOut(S_RS2, 32'h22, "mux_x4");
    expectOut(S_CNT, 2, "mux_instret2");

    // Both ports bypass in the same cycle, then both read from the array.
    applyStimulus(0, 0, 1, 0, 1, 5'd7, 32'h0, 32'hABCD, 5'd7, 5'd7);
    expectOut(S_RS1, 32'hABCD, "byp_rs1");
    expectOut(S_RS2, 32'hABCD, "byp_rs2");
    applyStimulus(0, 0, 0, 0, 1, 5'd7, 32'h0, 32'hABCD, 5'd7, 5'd7);
    expectOut(S_RS1, 32'hABCD, "byp_rs1_array");
    expectOut(S_RS2, 32'hABCD, "byp_rs2_array");
    expectOut(S_CNT, 3, "byp_instret");

    // A write to x0 is dropped but still counts as a retirement.
    applyStimulus(0, 0, 1, 0, 1, 5'd0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd7);
    expectOut(S_RS1, 0, "x0_same");
    expectOut(S_WE, 0, "x0_we");
    expectOut(S_DATA, 32'hFFFF_FFFF, "x0_wbdata");
    applyStimulus(0, 0, 0, 0, 1, 5'd0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd7);
    expectOut(S_RS1, 0, "x0_next");
    expectOut(S_CNT, 4, "x0_instret");

    // A held instruction commits exactly once, in its stall-low cycle.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0, 1, 5'd9, 32'h0, 32'h55, 5'd9, 5'd0);
      expectOut(S_WE, 0, "stall_we");
      expectOut(S_RS1, 0, "stall_no_bypass");
      expectOut(S_CNT, 4, "stall_instret");
    end
    applyStimulus(0, 0, 1, 0, 1, 5'd9, 32'h0, 32'h55, 5'd9, 5'd0);
    expectOut(S_WE, 1, "stall_release_we");
    expectOut(S_RS1, 32'h55, "stall_release_bypass");
    expectOut(S_CNT, 4, "stall_release_instret");
    applyStimulus(0, 0, 0, 0, 1, 5'd9, 32'h0, 32'h55, 5'd9, 5'd0);
    expectOut(S_RS1, 32'h55, "stall_array_x9");
    expectOut(S_CNT, 5, "stall_counted_once");

    // Back-to-back writes to the same register: the later write wins.
    applyStimulus(0, 0, 1, 0, 1, 5'd9, 32'h0, 32'h66, 5'd9, 5'd0);
    expectOut(S_RS1, 32'h66, "b2b_first");
    applyStimulus(0, 0, 1, 0, 1, 5'd9, 32'h0, 32'h77, 5'd9, 5'd0);
    expectOut(S_RS1, 32'h77, "b2b_second_bypass");
    expectOut(S_CNT, 6, "b2b_instret");
    applyStimulus(0, 0, 0, 0, 1, 5'd9, 32'h0, 32'h77, 5'd9, 5'd0);
    expectOut(S_RS1, 32'h77, "b2b_array");
    expectOut(S_CNT, 7, "b2b_instret2");

    // A commit with RegWrite low counts but does not write. A bubble does
    // neither.
    applyStimulus(0, 0, 1, 0, 0, 5'd3, 32'h0, 32'hBAD, 5'd3, 5'd0);
    expectOut(S_WE, 0, "nowrite_we");
    expectOut(S_RS1, 32'h11, "nowrite_no_bypass");
    applyStimulus(0, 0, 0, 0, 0, 5'd3, 32'h0, 32'hBAD, 5'd3, 5'd0);
    expectOut(S_RS1, 32'h11, "nowrite_x3_kept");
    expectOut(S_CNT, 8, "nowrite_counted");
    applyStimulus(0, 0, 0, 0, 0, 5'd3, 32'h0, 32'hBAD, 5'd3, 5'd0);
    expectOut(S_CNT, 8, "bubble_not_counted");

    // Counter wrap: preload all ones, then issue two commits.
    applyStimulus(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    applyStimulus(0, 0, 1, 0, 1, 5'd10, 32'h0, 32'h1, 5'd10, 5'd0);
    expectOut(S_RS1, 32'h1, "wrap_bypass_x10");
    applyStimulus(0, 0, 1, 0, 1, 5'd11, 32'h0, 32'h2, 5'd10, 5'd11);
    expectOut(S_CNT, 0, "wrap_to_zero");
    expectOut(S_RS1, 32'h1, "wrap_x10");
    applyStimulus(0, 0, 0, 0, 1, 5'd11, 32'h0, 32'h2, 5'd10, 5'd11);
    expectOut(S_CNT, 1, "wrap_to_one");
    expectOut(S_RS2, 32'h2, "wrap_x11");

    // Reset mid-stream: the in-flight instruction is neither written nor
    // counted.
    applyStimulus(1, 0, 1, 0, 1, 5'd12, 32'h0, 32'h123, 5'd12, 5'd3);
    expectOut(S_WE, 0, "midrst_we");
    applyStimulus(0, 0, 0, 0, 1, 5'd12, 32'h0, 32'h123, 5'd12, 5'd3);
    expectOut(S_RS1, 0, "midrst_x12");
    expectOut(S_RS2, 0, "midrst_x3_cleared");
    expectOut(S_CNT, 0, "midrst_instret");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage consumer of the MEM/WB pipeline register outputs, paired with the integer register file. It selects the writeback value (load data or ALU result) and commits it to a 32 x DATAWIDTH register file with x0 hardwired to zero. It serves two combinational read ports to ID with same-cycle write-through bypass, and keeps a 64-bit retired-instruction counter. It sits between MEMWB and the ID-stage operand fetch / forwarding unit.

## Interface
- DATAWIDTH, default 32: register and data width.
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- stall  input  1  same stall as MEMWB; high = the WB-stage instruction is being held.
- wb_valid  input  1  WB stage holds a real instruction (low for bubble/flush).
- MemtoReg  input  1  1 = write rd_MemData, 0 = write ALU_result.
- RegWrite  input  1  instruction writes rd.
- rd  input  5  destination register index.
- rd_MemData  input  DATAWIDTH  load data from MEM stage.
- ALU_result  input  DATAWIDTH  ALU result.
- rs1_addr, rs2_addr  input  5 each  ID-stage read indices.
- rs1_data, rs2_data  output  DATAWIDTH each  read data, combinational.
- wb_we_o  output  1  commit-write strobe this cycle, combinational.
- wb_rd_o  output  5  rd being committed, combinational.
- wb_data_o  output  DATAWIDTH  selected writeback value, combinational (for EX forwarding).
- instret  output  64  retired-instruction count, registered.

## Operation
- wb_data = MemtoReg ? rd_MemData : ALU_result; driven on wb_data_o regardless of enables.
- commit = wb_valid & ~stall & ~rst.
- we = commit & RegWrite & (rd != 0); drives wb_we_o; wb_rd_o = rd.
- On posedge with we: regs[rd] <= wb_data. No write in any other case.
- x0: never stored; reads of index 0 return 0 even if a write to rd=0 is attempted.
- Read port n: rsn_addr==0 -> 0; else we & (rd==rsn_addr) -> wb_data (bypass); else regs[rsn_addr]. Both ports independent; both may bypass in the same cycle.
- instret increments by 1 on each posedge with commit, regardless of RegWrite; wraps 2^64-1 -> 0.
- Stall semantics: MEMWB holds the same instruction across stall-high cycles. The instruction commits exactly once, in the cycle where stall is low. Repeated presentation under stall causes neither writes nor counts.

## Timing
- Reset: on posedge with rst high, regs[1..31] <= 0 and instret <= 0. Any commit presented that cycle is dropped. Combinational outputs during rst: wb_we_o = 0; rs*_data reflect regs and are 0 after the first reset edge.
- Reset mid-stream: an in-flight WB instruction at the reset edge is not written and not counted.
- Write latency: array updated at the commit edge. Readers see the new value in the same cycle via bypass, and from the array thereafter.
- Read latency: 0 cycles, purely combinational from address, array and WB inputs.
- Back-to-back writes to the same rd: the later one wins. Bypass always reflects the current WB instruction only.
- Simultaneous write and read of the same index: write-first (bypass value returned).
- wb_valid low or stall high: no write, no count, bypass inactive.

## Test plan
- Reset: hold rst 2 cycles with commit inputs active (RegWrite=1, rd=5, ALU_result=0xDEAD) -> all rs*_data read 0, instret=0, wb_we_o=0.
- Writeback mux: commit rd=3 ALU_result=0x11 MemtoReg=0, then rd=4 rd_MemData=0x22 MemtoReg=1 -> x3=0x11, x4=0x22, instret=2.
- Bypass: same cycle rd=7 wb_data=0xABCD, rs1_addr=rs2_addr=7 -> both read 0xABCD that cycle. Next cycle with wb_valid=0, both still read 0xABCD from the array.
- x0: commit rd=0 ALU_result=0xFFFF_FFFF with rs1_addr=0 -> rs1_data=0 same and next cycle, wb_we_o=0, instret still +1.
- Stall: present rd=9 data=0x55 with stall=1 for 3 cycles, then stall=0 for 1 -> exactly one write; instret +1 (not +4). x9 reads 0x55 (bypass) only in the stall-low cycle, and from the array afterwards.
- Counter wrap / bubbles: preload instret near 2^64-1 (force), 2 commits -> wraps to 1. wb_valid=0 cycles and RegWrite=0 commits -> no write, count only on the latter.
